// File: rtl/spi_slave_if.sv
// Bus bundle between the external SPI master / RAM block and spi_slave.
// The slave modport is the view seen by spi_slave; the master modport is
// the view of whoever drives the serial line and the RAM read response.
interface spi_slave_if;
  logic       MOSI;
  logic       SS_n;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  modport slave (
    input  MOSI,
    input  SS_n,
    input  tx_data,
    input  tx_valid,
    output MISO,
    output rx_data,
    output rx_valid
  );

  modport master (
    output MOSI,
    output SS_n,
    output tx_data,
    output tx_valid,
    input  MISO,
    input  rx_data,
    input  rx_valid
  );
endinterface

// File: rtl/spi_slave.sv
// SPI slave front end sampled on the system clock (one bit per clk).
// Deserializes 10-bit command/data words from MOSI into rx_data with a
// one-cycle rx_valid strobe. A read-data command (11 while a read address
// is pending) waits for the RAM's tx_valid and shifts tx_data out on MISO,
// MSB first. Raising SS_n in any active state abandons the frame.
module spi_slave (
  input  logic        clk,
  input  logic        rst,
  spi_slave_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    TX_WAIT  = 2'd0,
    TX_SHIFT = 2'd1,
    TX_DONE  = 2'd2
  } tx_phase_t;

  state_t     state_r;
  state_t     next_state_s;
  tx_phase_t  tx_phase_r;

  logic [3:0] bit_cnt_r;    // word bits captured in this frame (0..10)
  logic [8:0] shift_r;      // word bits 9..1 while the word is in flight
  logic [9:0] word_s;       // complete word when bit 0 is on MOSI
  logic [9:0] rx_data_r;
  logic       rx_valid_r;
  logic       rd_flag_r;    // a read address has been sent, next 11 is read-data
  logic [7:0] tx_shift_r;
  logic [3:0] tx_cnt_r;     // MISO bits still to present
  logic       miso_r;

  assign word_s       = {shift_r, bus.MOSI};
  assign bus.MISO     = miso_r;
  assign bus.rx_data  = rx_data_r;
  assign bus.rx_valid = rx_valid_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode: frame start, command dispatch and SS_n abort.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!bus.SS_n) begin
          next_state_s = CHK_CMD;
        end else begin
          next_state_s = IDLE;
        end
      end
      CHK_CMD: begin
        if (bus.SS_n) begin
          next_state_s = IDLE;
        end else if (!bus.MOSI) begin
          next_state_s = WRITE;
        end else if (rd_flag_r) begin
          next_state_s = READ_DATA;
        end else begin
          next_state_s = READ_ADD;
        end
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (bus.SS_n) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = state_r;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Datapath: word deserializer, rx strobe, rd_flag and MISO serializer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_r  <= 4'd0;
      shift_r    <= 9'd0;
      rx_data_r  <= 10'd0;
      rx_valid_r <= 1'b0;
      rd_flag_r  <= 1'b0;
      tx_shift_r <= 8'd0;
      tx_cnt_r   <= 4'd0;
      tx_phase_r <= TX_WAIT;
      miso_r     <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      if ((state_r != IDLE) && bus.SS_n) begin
        // Frame abandoned: partial word dropped, rd_flag kept.
        bit_cnt_r  <= 4'd0;
        miso_r     <= 1'b0;
        tx_cnt_r   <= 4'd0;
        tx_phase_r <= TX_WAIT;
      end else begin
        case (state_r)
          IDLE: begin
            bit_cnt_r  <= 4'd0;
            shift_r    <= 9'd0;
            miso_r     <= 1'b0;
            tx_cnt_r   <= 4'd0;
            tx_phase_r <= TX_WAIT;
          end
          CHK_CMD: begin
            shift_r   <= {shift_r[7:0], bus.MOSI};
            bit_cnt_r <= 4'd1;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (bit_cnt_r < 4'd9) begin
              shift_r   <= {shift_r[7:0], bus.MOSI};
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end else if (bit_cnt_r == 4'd9) begin
              // Bit 0 on the line: publish the word whatever its command.
              rx_data_r  <= word_s;
              rx_valid_r <= 1'b1;
              bit_cnt_r  <= 4'd10;
              if (word_s[9:8] == 2'b10) begin
                rd_flag_r <= 1'b1;
              end else if (word_s[9:8] == 2'b11) begin
                rd_flag_r <= 1'b0;
              end else begin
                rd_flag_r <= rd_flag_r;
              end
            end else if (state_r == READ_DATA) begin
              // Word done; only READ_DATA answers the RAM, once per frame.
              case (tx_phase_r)
                TX_WAIT: begin
                  if (bus.tx_valid) begin
                    tx_shift_r <= bus.tx_data;
                    tx_cnt_r   <= 4'd8;
                    tx_phase_r <= TX_SHIFT;
                  end
                end
                TX_SHIFT: begin
                  if (tx_cnt_r != 4'd0) begin
                    miso_r     <= tx_shift_r[7];
                    tx_shift_r <= {tx_shift_r[6:0], 1'b0};
                    tx_cnt_r   <= tx_cnt_r - 4'd1;
                  end else begin
                    miso_r     <= 1'b0;
                    tx_phase_r <= TX_DONE;
                  end
                end
                TX_DONE: begin
                  miso_r <= 1'b0;
                end
                default: begin
                  miso_r     <= 1'b0;
                  tx_phase_r <= TX_DONE;
                end
              endcase
            end else begin
              // Extra MOSI bits after the word are ignored.
              bit_cnt_r <= bit_cnt_r;
            end
          end
          default: begin
            bit_cnt_r <= 4'd0;
            miso_r    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: write frames, read address/data with a
// RAM-style tx_valid response, abort, async reset and spurious tx_valid.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_spi_slave;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [7:0] byte_v;

  spi_slave_if bus ();

  spi_slave dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive SS_n low then nbits word bits MSB first; checks during the word.
  task automatic frame(input logic [9:0] w, input int nbits, input logic txv);
    bus.SS_n     = 1'b0;
    bus.tx_valid = txv;
    @(negedge clk);
    for (int i = 9; i >= 10 - nbits; i--) begin
      bus.MOSI = w[i];
      @(negedge clk);
      if (i != 0) chk("rx_valid_mid_word", {9'd0, bus.rx_valid}, 10'd0);
      chk("miso_during_word", {9'd0, bus.MISO}, 10'd0);
    end
    if (nbits == 10) begin
      chk("rx_valid_pulse", {9'd0, bus.rx_valid}, 10'd1);
      chk("rx_data_word", bus.rx_data, w);
    end
  endtask

  task automatic end_frame();
    bus.SS_n     = 1'b1;
    bus.tx_valid = 1'b0;
    bus.MOSI     = 1'b0;
    @(negedge clk);
    chk("rx_valid_after", {9'd0, bus.rx_valid}, 10'd0);
    chk("miso_after", {9'd0, bus.MISO}, 10'd0);
  endtask

  // Offer RAM data after a word that must not be answered; MISO stays 0.
  task automatic no_miso();
    @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hFF;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("miso_no_read", {9'd0, bus.MISO}, 10'd0);
    end
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    rst          = 1'b1;
    bus.SS_n     = 1'b1;
    bus.MOSI     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_miso", {9'd0, bus.MISO}, 10'd0);
    chk("reset_rx_valid", {9'd0, bus.rx_valid}, 10'd0);
    chk("reset_rx_data", bus.rx_data, 10'd0);
    rst = 1'b0;
    @(negedge clk);

    // Write address, then write data, then extra bits ignored in-frame.
    frame(10'h005, 10, 1'b0);
    end_frame();
    frame(10'h1A5, 10, 1'b0);
    bus.MOSI = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("extra_bits_ignored", {9'd0, bus.rx_valid}, 10'd0);
    end
    end_frame();

    // rd_flag still 0 after the 01 word: an 11 word lands in READ_ADD.
    frame(10'h3C3, 10, 1'b0);
    no_miso();
    end_frame();

    // Read address, then read data with RAM answering one cycle later.
    frame(10'h205, 10, 1'b0);
    end_frame();
    frame(10'h33C, 10, 1'b0);
    @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hA5;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    chk("miso_before_first_bit", {9'd0, bus.MISO}, 10'd0);
    byte_v = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      chk("miso_read_bit", {9'd0, bus.MISO}, {9'd0, byte_v[i]});
      // Second tx_valid with different data in mid-serialization.
      bus.tx_valid = (i == 4);
      bus.tx_data  = (i == 4) ? 8'hFF : 8'hA5;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("miso_after_read", {9'd0, bus.MISO}, 10'd0);
    end
    end_frame();

    // rd_flag cleared by the 11 word: next 11 is READ_ADD again.
    frame(10'h3C3, 10, 1'b0);
    no_miso();
    end_frame();

    // Abort after 6 bits: no strobe, rx_data held, rd_flag unchanged.
    frame(10'h205, 10, 1'b0);
    end_frame();
    frame(10'h3FF, 6, 1'b0);
    end_frame();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_rx_valid", {9'd0, bus.rx_valid}, 10'd0);
    end
    chk("abort_rx_data_held", bus.rx_data, 10'h205);
    frame(10'h0F0, 10, 1'b0);
    end_frame();

    // rd_flag survived the abort: 11 word enters READ_DATA; reset at bit 3.
    frame(10'h311, 10, 1'b0);
    @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h5A;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    byte_v = 8'h5A;
    for (int i = 7; i >= 3; i--) begin
      @(negedge clk);
      chk("miso_read2_bit", {9'd0, bus.MISO}, {9'd0, byte_v[i]});
    end
    rst = 1'b1;
    #1;
    chk("async_rst_miso", {9'd0, bus.MISO}, 10'd0);
    chk("async_rst_rx_valid", {9'd0, bus.rx_valid}, 10'd0);
    chk("async_rst_rx_data", bus.rx_data, 10'd0);
    bus.SS_n = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    frame(10'h3A0, 10, 1'b0);
    no_miso();
    end_frame();

    // Reset clears a pending read address.
    frame(10'h205, 10, 1'b0);
    end_frame();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    frame(10'h3C3, 10, 1'b0);
    no_miso();
    end_frame();

    // Spurious tx_valid held high through a WRITE frame.
    frame(10'h0AA, 10, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("miso_spurious_tx", {9'd0, bus.MISO}, 10'd0);
    end
    end_frame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
